// File: rtl/data_mem_controller.sv
// Multi-channel arbiter between per-thread LSU data requests and external memory.
// Each channel claims the lowest-index unclaimed requester, relays it to memory, returns the response.
module data_mem_controller #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
  output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);

  localparam int unsigned CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_WRITE_WAIT,
    ST_READ_RELAY,
    ST_WRITE_RELAY
  } state_t;

  state_t        state_q [NUM_CHANNELS];
  state_t        state_d [NUM_CHANNELS];
  logic [CW-1:0] owner_q [NUM_CHANNELS];
  logic [CW-1:0] owner_d [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
  logic [NUM_CONSUMERS-1:0]                crd_rdy_d, cwr_rdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_data_d;
  logic [NUM_CHANNELS-1:0]                 mrd_vld_d, mwr_vld_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mrd_addr_d, mwr_addr_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwr_data_d;

  // State, claim mask and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        owner_q[c] <= '0;
      end
      claim_q              <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        owner_q[c] <= owner_d[c];
      end
      claim_q              <= claim_d;
      consumer_read_ready  <= crd_rdy_d;
      consumer_read_data   <= crd_data_d;
      consumer_write_ready <= cwr_rdy_d;
      mem_read_valid       <= mrd_vld_d;
      mem_read_address     <= mrd_addr_d;
      mem_write_valid      <= mwr_vld_d;
      mem_write_address    <= mwr_addr_d;
      mem_write_data       <= mwr_data_d;
    end
  end

  // Next state for every channel; lower channels claim first within a cycle.
  always_comb begin : next_logic
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [CW-1:0]            pick;

    taken      = '0;
    found      = 1'b0;
    pick       = '0;
    claim_d    = claim_q;
    crd_rdy_d  = consumer_read_ready;
    crd_data_d = consumer_read_data;
    cwr_rdy_d  = consumer_write_ready;
    mrd_vld_d  = mem_read_valid;
    mrd_addr_d = mem_read_address;
    mwr_vld_d  = mem_write_valid;
    mwr_addr_d = mem_write_address;
    mwr_data_d = mem_write_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      owner_d[c] = owner_q[c];
    end

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        ST_IDLE: begin
          // Scan against the registered mask so a consumer freed this edge waits one cycle.
          found = 1'b0;
          pick  = '0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && (consumer_read_valid[i] || consumer_write_valid[i]) &&
                !claim_q[i] && !taken[i]) begin
              found = 1'b1;
              pick  = CW'(i);
            end
          end
          if (found) begin
            taken[pick]   = 1'b1;
            claim_d[pick] = 1'b1;
            owner_d[c]    = pick;
            if (consumer_read_valid[pick]) begin
              mrd_vld_d[c]  = 1'b1;
              mrd_addr_d[c] = consumer_read_address[pick];
              state_d[c]    = ST_READ_WAIT;
            end else begin
              mwr_vld_d[c]  = 1'b1;
              mwr_addr_d[c] = consumer_write_address[pick];
              mwr_data_d[c] = consumer_write_data[pick];
              state_d[c]    = ST_WRITE_WAIT;
            end
          end
        end
        ST_READ_WAIT: begin
          if (mem_read_ready[c]) begin
            mrd_vld_d[c]              = 1'b0;
            crd_data_d[owner_q[c]]    = mem_read_data[c];
            crd_rdy_d[owner_q[c]]     = 1'b1;
            state_d[c]                = ST_READ_RELAY;
          end
        end
        ST_WRITE_WAIT: begin
          if (mem_write_ready[c]) begin
            mwr_vld_d[c]              = 1'b0;
            cwr_rdy_d[owner_q[c]]     = 1'b1;
            state_d[c]                = ST_WRITE_RELAY;
          end
        end
        ST_READ_RELAY: begin
          if (!consumer_read_valid[owner_q[c]]) begin
            crd_rdy_d[owner_q[c]] = 1'b0;
            claim_d[owner_q[c]]   = 1'b0;
            state_d[c]            = ST_IDLE;
          end
        end
        ST_WRITE_RELAY: begin
          if (!consumer_write_valid[owner_q[c]]) begin
            cwr_rdy_d[owner_q[c]] = 1'b0;
            claim_d[owner_q[c]]   = 1'b0;
            state_d[c]            = ST_IDLE;
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: vector table, directed corner sequences,
// and concurrent random traffic checked against a last-write-wins memory model.
module tb_data_mem_controller;

  localparam int NC  = 8;
  localparam int NCH = 4;

  logic clk;
  logic reset;
  logic [NC-1:0]            consumer_read_valid, consumer_read_ready;
  logic [NC-1:0]            consumer_write_valid, consumer_write_ready;
  logic [NC-1:0][7:0]       consumer_read_address, consumer_read_data;
  logic [NC-1:0][7:0]       consumer_write_address, consumer_write_data;
  logic [NCH-1:0]           mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [NCH-1:0][7:0]      mem_read_address, mem_read_data;
  logic [NCH-1:0][7:0]      mem_write_address, mem_write_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];
  bit         auto_mem;
  int         fixed_delay;

  typedef struct {
    int         cons;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [11];

  data_mem_controller #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Memory model: one-cycle ready pulse after a per-request delay.
  initial begin : memory_model
    int  rd_wait [NCH];
    int  wr_wait [NCH];
    bit  rd_busy [NCH];
    bit  wr_busy [NCH];
    mem_read_ready  = '0;
    mem_read_data   = '0;
    mem_write_ready = '0;
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a) ^ 8'hC3;
    for (int c = 0; c < NCH; c++) begin
      rd_wait[c] = 0; wr_wait[c] = 0; rd_busy[c] = 1'b0; wr_busy[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        for (int c = 0; c < NCH; c++) begin
          if (mem_read_ready[c]) mem_read_ready[c] = 1'b0;
          else if (mem_read_valid[c]) begin
            if (!rd_busy[c]) begin
              rd_busy[c] = 1'b1;
              rd_wait[c] = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
            if (rd_wait[c] == 0) begin
              mem_read_ready[c] = 1'b1;
              mem_read_data[c]  = mem_arr[mem_read_address[c]];
              rd_busy[c]        = 1'b0;
            end else rd_wait[c]--;
          end
          if (mem_write_ready[c]) mem_write_ready[c] = 1'b0;
          else if (mem_write_valid[c]) begin
            if (!wr_busy[c]) begin
              wr_busy[c] = 1'b1;
              wr_wait[c] = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
            if (wr_wait[c] == 0) begin
              mem_write_ready[c]            = 1'b1;
              mem_arr[mem_write_address[c]] = mem_write_data[c];
              wr_busy[c]                    = 1'b0;
            end else wr_wait[c]--;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int k, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
    if (wr) begin
      consumer_write_address[k] = addr;
      consumer_write_data[k]    = wdata;
      consumer_write_valid[k]   = 1'b1;
    end else begin
      consumer_read_address[k]  = addr;
      consumer_read_valid[k]    = 1'b1;
    end
  endtask

  // Wait (bounded) for ready, capture data, drop valid, confirm ready clears next edge.
  task automatic finish_txn(input int k, input bit wr, output logic [7:0] rdata);
    int cnt = 0;
    while (!(wr ? consumer_write_ready[k] : consumer_read_ready[k]) && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("ready_timeout_c%0d", k), 32'(cnt < 600), 32'd1);
    rdata = consumer_read_data[k];
    if (wr) consumer_write_valid[k] = 1'b0;
    else    consumer_read_valid[k]  = 1'b0;
    @(negedge clk);
    check($sformatf("ready_clear_c%0d", k),
          32'(wr ? consumer_write_ready[k] : consumer_read_ready[k]), 32'd0);
  endtask

  task automatic do_txn(input int k, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rdata);
    issue(k, wr, addr, wdata);
    finish_txn(k, wr, rdata);
  endtask

  task automatic run_consumer(input int k);
    logic [7:0] addr, data, rdata;
    bit wr;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wr   = 1'($urandom_range(0, 1));
      addr = {1'b1, 4'($urandom), 3'(k)};
      data = 8'($urandom);
      do_txn(k, wr, addr, data, rdata);
      if (wr) ref_mem[addr] = data;
      else    check($sformatf("rand_rd_c%0d_a%02h", k, addr), 32'(rdata), 32'(ref_mem[addr]));
    end
  endtask

  initial begin : stimulus
    logic [7:0] rdata;
    logic [NC-1:0] pending;
    int cyc;

    vecs[0]  = '{3, 1'b0, 8'h12, 8'h00, 8'hD1};
    vecs[1]  = '{2, 1'b1, 8'h12, 8'hAB, 8'h00};
    vecs[2]  = '{5, 1'b0, 8'h12, 8'h00, 8'hAB};
    vecs[3]  = '{7, 1'b0, 8'h7F, 8'h00, 8'hBC};
    vecs[4]  = '{0, 1'b1, 8'h7F, 8'h00, 8'h00};
    vecs[5]  = '{0, 1'b0, 8'h7F, 8'h00, 8'h00};
    vecs[6]  = '{6, 1'b0, 8'h00, 8'h00, 8'hC3};
    vecs[7]  = '{1, 1'b1, 8'h00, 8'hA5, 8'h00};
    vecs[8]  = '{4, 1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[9]  = '{2, 1'b1, 8'h21, 8'h5A, 8'h00};
    vecs[10] = '{5, 1'b0, 8'h21, 8'h00, 8'h5A};
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'hC3;

    auto_mem               = 1'b1;
    fixed_delay            = -1;
    reset                  = 1'b0;
    consumer_read_valid    = '1;
    consumer_write_valid   = '1;
    for (int i = 0; i < NC; i++) begin
      consumer_read_address[i]  = 8'(i + 1);
      consumer_write_address[i] = 8'(i + 9);
      consumer_write_data[i]    = 8'(i + 17);
    end

    // Reset held for two edges with every request asserted.
    repeat (2) @(negedge clk);
    check("reset_outputs_zero",
          32'(|{consumer_read_ready, consumer_read_data, consumer_write_ready,
                mem_read_valid, mem_read_address, mem_write_valid,
                mem_write_address, mem_write_data}), 32'd0);
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    reset                = 1'b1;
    @(negedge clk);
    check("post_reset_no_claim", 32'({mem_read_valid, mem_write_valid}), 32'd0);

    // Vector table: sequential single transactions.
    for (int v = 0; v < 11; v++) begin
      do_txn(vecs[v].cons, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rdata);
      if (!vecs[v].wr) check($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp));
    end

    // Single read with a 2-cycle memory reply.
    fixed_delay = 2;
    issue(3, 1'b0, 8'h12, 8'h00);
    @(negedge clk);
    check("single_mem_valid", 32'(mem_read_valid), 32'h1);
    check("single_mem_addr", 32'(mem_read_address[0]), 32'h12);
    repeat (2) @(negedge clk);
    check("single_not_early", 32'(consumer_read_ready[3]), 32'd0);
    @(negedge clk);
    check("single_ready", 32'(consumer_read_ready[3]), 32'd1);
    check("single_data", 32'(consumer_read_data[3]), 32'hAB);
    check("single_mem_valid_drop", 32'(mem_read_valid[0]), 32'd0);
    finish_txn(3, 1'b0, rdata);
    fixed_delay = -1;

    // Contention: all eight consumers read at once.
    for (int i = 0; i < NC; i++) issue(i, 1'b0, 8'(8'h40 + i), 8'h00);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("cont_ch%0d_valid", c), 32'(mem_read_valid[c]), 32'd1);
      check($sformatf("cont_ch%0d_addr", c), 32'(mem_read_address[c]), 32'(8'h40 + c));
    end
    pending = '1;
    cyc     = 0;
    while (pending != '0 && cyc < 400) begin
      for (int i = 0; i < NC; i++) begin
        if (pending[i] && consumer_read_ready[i]) begin
          check($sformatf("cont_data_c%0d", i), 32'(consumer_read_data[i]),
                32'((8'h40 + i) ^ 8'hC3));
          consumer_read_valid[i] = 1'b0;
          pending[i]             = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("cont_all_done", 32'(pending), 32'd0);
    @(negedge clk);
    check("cont_readies_clear", 32'(consumer_read_ready), 32'd0);

    // Simultaneous read and write from consumer 0: read goes first.
    issue(0, 1'b0, 8'h30, 8'h00);
    issue(0, 1'b1, 8'h20, 8'h5A);
    @(negedge clk);
    check("rw_read_first", 32'(mem_read_valid), 32'h1);
    check("rw_no_write_yet", 32'(mem_write_valid), 32'h0);
    finish_txn(0, 1'b0, rdata);
    check("rw_read_data", 32'(rdata), 32'h30 ^ 32'hC3);
    finish_txn(0, 1'b1, rdata);
    do_txn(4, 1'b0, 8'h20, 8'h00, rdata);
    check("rw_write_landed", 32'(rdata), 32'h5A);

    // Back-to-back: re-request the cycle after ready drops.
    do_txn(1, 1'b0, 8'h21, 8'h00, rdata);
    check("b2b_first_data", 32'(rdata), 32'h5A);
    issue(1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("b2b_no_stale_ready", 32'(consumer_read_ready[1]), 32'd0);
    check("b2b_reclaimed", 32'(mem_read_valid != '0), 32'd1);
    finish_txn(1, 1'b0, rdata);
    check("b2b_second_data", 32'(rdata), 32'hA5);

    // Reset while channel 2 waits on memory.
    auto_mem = 1'b0;
    for (int i = 0; i < 3; i++) issue(i, 1'b0, 8'(8'h90 + i), 8'h00);
    @(negedge clk);
    check("midrst_pre_valid", 32'(mem_read_valid), 32'h7);
    check("midrst_ch2_addr", 32'(mem_read_address[2]), 32'h92);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid_drop", 32'(mem_read_valid), 32'h0);
    check("midrst_no_ready", 32'(consumer_read_ready), 32'h0);
    consumer_read_valid = '0;
    reset               = 1'b1;
    auto_mem            = 1'b1;
    @(negedge clk);
    issue(2, 1'b0, 8'h92, 8'h00);
    @(negedge clk);
    check("midrst_reclaim_ch0", 32'(mem_read_valid), 32'h1);
    check("midrst_reclaim_addr", 32'(mem_read_address[0]), 32'h92);
    finish_txn(2, 1'b0, rdata);
    check("midrst_data", 32'(rdata), 32'h92 ^ 32'hC3);

    // Concurrent random traffic; each consumer owns addresses ending in its index.
    fork
      run_consumer(0);
      run_consumer(1);
      run_consumer(2);
      run_consumer(3);
      run_consumer(4);
      run_consumer(5);
      run_consumer(6);
      run_consumer(7);
    join
    repeat (2) @(negedge clk);
    check("final_idle",
          32'({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
